rr_mux: RTL and testbench
=========================

Name: rr_mux

Overview:
- Parametrised N-channel, W-bit round-robin multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the fixed 4:1 single-bit selector. Channel selection is made internally by a fair arbiter, not by an external select.
- The result is held in a one-entry output register.
- Sits between multiple producer blocks and one shared consumer (e.g. shared bus or ALU port).

Parameters:
- N_CH, 4, number of input channels; legal range 2..16, need not be a power of 2.
- WIDTH, 8, data width of each channel in bits.
- CH_W, $clog2(N_CH), width of the channel-index fields; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_CH  per-channel request; bit i belongs to channel i.
- in_data  in  N_CH x WIDTH  per-channel data; unpacked array indexed by channel.
- in_ready  out  N_CH  per-channel accept; combinational.
- out_valid  out  1  output register holds a valid item.
- out_data  out  WIDTH  registered data.
- out_ch  out  CH_W  index of the channel that produced out_data; registered.
- out_ready  in  1  consumer accepts the item.

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is combinational and therefore =0 while out_valid=0 only if no in_valid is asserted.
  - rst overrides any transfer in the same cycle; an item in flight is dropped.
- Transfer definitions:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at posedge.
  - Output transfer: out_valid && out_ready at posedge.
- Load condition: load = !out_valid || out_ready. This gives full throughput of 1 item/cycle.
- Grant:
  - Combinationally choose the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - grant is one-hot or zero.
  - in_ready[i] = grant[i] && load.
  - At most one in_ready bit is high in any cycle.
- On an input transfer from channel g:
  - out_data<=in_data[g], out_ch<=g, out_valid<=1.
  - ptr<=g+1; wraps to 0 when g=N_CH-1.
- Output transfer with no input transfer in the same cycle: out_valid<=0; out_data and out_ch hold their last values.
- Simultaneous output transfer and input transfer: the register is replaced in the same edge with no bubble; out_valid stays 1.
- Latency: in_data is visible on out_data exactly 1 cycle after its input transfer.
- Backpressure:
  - out_valid=1 && out_ready=0 gives all in_ready=0.
  - Registered outputs stay stable; ptr is frozen.
- No requests (in_valid=0): ptr unchanged; no grant.
- Fairness: each continuously requesting channel is served at least once every N_CH output transfers.
- Input rule: in_valid must not depend combinationally on in_ready; inputs may drop valid freely (no input-side lock).

Optional Feature:
- Macro: RR_MUX_FIXED_PRI_EN.
- Defined:
  - Arbitration is fixed priority; the lowest asserted index wins.
  - ptr register is removed; fairness is not guaranteed.
  - All other behaviour and ports are identical.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package rr_mux_pkg holds:
  - RR_MUX_MAX_CH=16.
  - A function next_idx(idx, n) that wraps modulo n.
  - typedef ch_idx_t sized for RR_MUX_MAX_CH, used for ptr/out_ch before truncation to CH_W.
- Sub-module rr_arbiter (param N_CH) holds:
  - Ports: clk, rst, req[N_CH], advance, grant[N_CH] (one-hot), grant_idx.
  - ptr register and the rotate/priority search.
- rr_mux instantiates rr_arbiter and contains the output register and ready logic.

Test Plan:
1. Reset: hold rst=1 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0. The first grant after release goes to channel 0.
2. All four channels request continuously with data 8'hA0..8'hA3 and out_ready=1 -> out_ch sequence 0,1,2,3,0,... and out_data A0,A1,A2,A3. One transfer per cycle, no bubbles.
3. Backpressure: out_ready=0 for 3 cycles while out_valid=1 holding 8'h55 from ch2 -> in_ready=0, out_data/out_ch stable for 3 cycles. When released, the next grant goes to ch3.
4. Wrap and skip: ptr=3, in_valid=4'b0101 -> grant ch0 then ch2; ch1 and ch3 never get in_ready.
5. Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ptr=0; the item is lost.
6. Build with RR_MUX_FIXED_PRI_EN, N_CH=5, WIDTH=16, all five channels requesting continuously -> ch0 wins every cycle. Then drop ch0 -> ch1 wins every cycle.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin multiplexer.
// Optional build macro used by this slice: RR_MUX_FIXED_PRI_EN.
package rr_mux_pkg;

  localparam int RR_MUX_MAX_CH = 16;

  // Wide enough for any legal channel index; truncated to CH_W at the ports.
  typedef logic [$clog2(RR_MUX_MAX_CH)-1:0] ch_idx_t;

  function automatic ch_idx_t next_idx(input ch_idx_t idx, input int n);
    int t;
    t = int'(idx) + 1;
    if (t >= n) t = 0;
    return ch_idx_t'(t);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Fair arbiter: picks the first requester starting at ptr, moving ptr past the winner.
// With RR_MUX_FIXED_PRI_EN defined, the lowest requesting index always wins and ptr is removed.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx
);

  ch_idx_t         sel_idx;
  logic            found;
  int              base;
  int              idx;
  logic [CH_W-1:0] idx_w;

`ifdef RR_MUX_FIXED_PRI_EN
  assign base = 0;
`else
  ch_idx_t ptr_reg;

  assign base = int'(ptr_reg);

  // ptr only moves on an accepted item so backpressure freezes the rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= next_idx(sel_idx, N_CH);
    end
  end
`endif

  always_comb begin
    grant   = '0;
    sel_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = base + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_w = CH_W'(idx);
      if (!found && req[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        sel_idx      = ch_idx_t'(idx);
      end
    end
  end

  assign grant_idx = CH_W'(sel_idx);

endmodule

// File: rtl/rr_mux.sv
// N-channel round-robin multiplexer with valid/ready on every port and a one-entry output register.
// Define RR_MUX_FIXED_PRI_EN for fixed lowest-index-first arbitration.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_valid,
  input  logic [WIDTH-1:0] in_data [N_CH],
  output logic [N_CH-1:0]  in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  input  logic             out_ready
);

  logic [N_CH-1:0]  grant;
  logic [CH_W-1:0]  grant_idx;
  logic             load;
  logic             xfer;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [CH_W-1:0]  out_ch_reg;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (in_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Register may be refilled whenever it is empty or being drained this edge.
  assign load     = !out_valid_reg || out_ready;
  assign in_ready = grant & {N_CH{load}};
  assign xfer     = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data[grant_idx];
      out_ch_reg    <= grant_idx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux with a scoreboard of expected output items.
// Define RR_MUX_FIXED_PRI_EN to exercise the fixed-priority build (5 x 16-bit).
module tb_rr_mux;

`ifdef RR_MUX_FIXED_PRI_EN
  localparam int N = 5;
  localparam int W = 16;
`else
  localparam int N = 4;
  localparam int W = 8;
`endif
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [W-1:0]  in_data [N];
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ch;
  logic          out_ready;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  data;
  } item_t;

  item_t sb[$];
  int    mptr;
  int    n_assert = 0;
  int    n_fail   = 0;

  rr_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after mptr, wrapping.
  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    int       g;
    bit       mv;
    logic [N-1:0] er;
    #3;
    mv = (sb.size() > 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
    if (mv) begin
      chk("out_data", 32'(out_data), 32'(sb[0].data));
      chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
    end
    g  = exp_grant();
    er = '0;
    if (g >= 0 && (!mv || out_ready)) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (mv && out_ready) void'(sb.pop_front());
    if (er != '0) begin
      sb.push_back('{ch: CW'(g), data: in_data[g]});
`ifndef RR_MUX_FIXED_PRI_EN
      mptr = (g + 1) % N;
`endif
    end
    $display("t=%0t in_valid=%b in_ready=%b out_valid=%b out_ch=%0d out_data=%0h out_ready=%b",
             $time, in_valid, in_ready, out_valid, out_ch, out_data, out_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    mptr = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    $display("t=%0t reset applied", $time);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    out_ready = 1'b0;
    mptr      = 0;
    for (int i = 0; i < N; i++) in_data[i] = W'(8'hA0 + i);
    @(posedge clk);
    #1;

    // Reset held with all channels requesting, then first grant goes to ch0
    do_reset();
    do_reset();
    out_ready = 1'b1;
    cycle();

`ifdef RR_MUX_FIXED_PRI_EN
    // Fixed priority: ch0 wins every cycle, then ch1 once ch0 drops
    for (int i = 0; i < N; i++) in_data[i] = W'(16'h1000 + i);
    repeat (5) begin
      chk("fixed_ch0", 32'(in_ready), 32'd1);
      cycle();
    end
    in_valid = 5'b11110;
    #1;
    repeat (5) begin
      chk("fixed_ch1", 32'(in_ready), 32'd2);
      cycle();
    end
`else
    // Continuous requests at full throughput: ch 0,1,2,3,0,...
    repeat (8) cycle();

    // Backpressure holding 8'h55 from ch2, then release to ch3
    do_reset();
    in_valid   = 4'b0100;
    in_data[2] = 8'h55;
    cycle();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("bp_data", 32'(out_data), 32'h55);
      chk("bp_ch", 32'(out_ch), 32'd2);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ch3", 32'(in_ready), 32'b1000);
    cycle();

    // Wrap and skip from ptr=3 with ch0/ch2 requesting
    do_reset();
    in_valid = 4'b0100;
    cycle();
    in_valid = 4'b0101;
    #1;
    chk("wrap_ch0", 32'(in_ready), 32'b0001);
    cycle();
    chk("skip_ch2", 32'(in_ready), 32'b0100);
    repeat (4) begin
      chk("skip_never_1_3", 32'(in_ready & 4'b1010), 32'd0);
      cycle();
    end

    // Reset while stalled drops the held item and returns ptr to 0
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    cycle();
    do_reset();
    out_ready = 1'b1;
    #1;
    chk("post_rst_grant_ch0", 32'(in_ready), 32'b0001);
    cycle();
`endif

    // Drain the scoreboard
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (2) cycle();
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
